// File: rtl/bidir_pkg.sv
// Shared types for the bidirectional pad bank.
// State encoding, direction codes and counter sizing helper.
package bidir_pkg;

    typedef enum logic [1:0] {
        LISTEN   = 2'd0,
        TURN_DRV = 2'd1,
        DRIVE    = 2'd2,
        TURN_RCV = 2'd3
    } bidir_state_t;

    localparam logic DIR_RCV = 1'b0;
    localparam logic DIR_DRV = 1'b1;

    // Turn counter width: max(1, clog2(tc+1)).
    function automatic int turn_w(input int tc);
        return ($clog2(tc + 1) < 1) ? 1 : $clog2(tc + 1);
    endfunction

endpackage

// File: rtl/bidir_port_bank_pad_sync.sv
// pad_sync: reset-to-0 multi-stage input synchroniser.
// Ports: clk, rst_n (sync, active-low), din (raw pads), dout (last stage).
module pad_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_port_bank.sv
// bidir_port_bank: registered tristate pad bank with turnaround sequencer.
// Ports: dir_valid/dir_drive/dir_ready request, wr_* output regs, pad, rd_* sync input, driving.
module bidir_port_bank
    import bidir_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_valid,
    input  logic             dir_drive,
    output logic             dir_ready,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_oe,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             driving
);

    localparam int TW = turn_w(TURN_CYCLES);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] TURN_LOAD =
        TW'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES);

    bidir_state_t     state_q, state_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic             accept;

    assign dir_ready = (state_q == LISTEN) || (state_q == DRIVE);
    assign accept    = dir_valid && dir_ready;

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            LISTEN: begin
                if (accept && dir_drive == DIR_DRV) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = TURN_DRV;
                        turn_d  = TURN_LOAD;
                    end
                end
            end
            TURN_DRV: begin
                if (turn_q == '0) state_d = DRIVE;
                else              turn_d  = turn_q - TW'(1);
            end
            DRIVE: begin
                if (accept && dir_drive == DIR_RCV) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = LISTEN;
                    end else begin
                        state_d = TURN_RCV;
                        turn_d  = TURN_LOAD;
                    end
                end
            end
            TURN_RCV: begin
                if (turn_q == '0) state_d = LISTEN;
                else              turn_d  = turn_q - TW'(1);
            end
            default: state_d = LISTEN;
        endcase
    end

    // Settle count restarts whenever we are outside LISTEN, so it
    // reads zero on the first LISTEN cycle and saturates afterwards.
    always_comb begin
        settle_d = settle_q;
        if (state_q != LISTEN) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + SW'(1);
        end
    end

    always_comb begin
        dout_d = dout_q;
        oe_d   = oe_q;
        if (wr_en) begin
            dout_d = wr_data;
            oe_d   = wr_oe;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LISTEN;
            turn_q   <= '0;
            settle_q <= '0;
            dout_q   <= '0;
            oe_q     <= '0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            settle_q <= settle_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
        end
    end

    assign driving  = (state_q == DRIVE);
    assign rd_valid = (state_q == LISTEN) && (settle_q == SETTLE_MAX);

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign pad[g] = (driving && oe_q[g]) ? dout_q[g] : 1'bz;
    end

    pad_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pad),
        .dout (rd_data)
    );

endmodule

// File: tb/tb_bidir_port_bank.sv
// Scoreboard bench for bidir_port_bank (TURN_CYCLES=2 and 0 builds).
// Driver queues per-edge expectations; monitor checks them after each edge.
module tb_bidir_port_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dir_valid, dir_drive, wr_en;
    logic [7:0] wr_data, wr_oe;
    logic       dir_ready, rd_valid, driving;
    logic [7:0] rd_data;
    logic       dir_ready0, rd_valid0, driving0;
    logic [7:0] rd_data0;
    wire  [7:0] pad;
    wire  [7:0] pad0;
    logic [7:0] ext_oe, ext_val, ext0_oe, ext0_val;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_ext
        assign pad[g]  = ext_oe[g]  ? ext_val[g]  : 1'bz;
        assign pad0[g] = ext0_oe[g] ? ext0_val[g] : 1'bz;
    end

    bidir_port_bank #(
        .WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dir_valid(dir_valid), .dir_drive(dir_drive),
        .dir_ready(dir_ready),
        .wr_en(wr_en), .wr_data(wr_data), .wr_oe(wr_oe),
        .pad(pad),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .driving(driving)
    );

    bidir_port_bank #(
        .WIDTH(8), .TURN_CYCLES(0), .SYNC_STAGES(2)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .dir_valid(dir_valid), .dir_drive(dir_drive),
        .dir_ready(dir_ready0),
        .wr_en(wr_en), .wr_data(wr_data), .wr_oe(wr_oe),
        .pad(pad0),
        .rd_data(rd_data0), .rd_valid(rd_valid0),
        .driving(driving0)
    );

    typedef struct {
        int         cyc;
        string      name;
        bit         sel;
        logic [7:0] pm, pe, rm, re;
        bit         cf, v, d, r;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    function automatic exp_t ex(
        input string n, input bit s,
        input logic [7:0] pm, input logic [7:0] pe,
        input logic [7:0] rm, input logic [7:0] re,
        input bit cf, input bit v, input bit d, input bit r);
        exp_t e;
        e.cyc = 0; e.name = n; e.sel = s;
        e.pm = pm; e.pe = pe; e.rm = rm; e.re = re;
        e.cf = cf; e.v = v; e.d = d; e.r = r;
        return e;
    endfunction

    task automatic cmp8(input string n, input logic [7:0] a,
                        input logic [7:0] e, input logic [7:0] m);
        total++;
        if ((a & m) !== (e & m)) begin
            bad++;
            $display("FAIL %s: got %h want %h mask %h",
                     n, a & m, e & m, m);
        end
    endtask

    task automatic cmp1(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    // Monitor: after each edge, check every expectation aimed at it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (q.size() > 0 && q[0].cyc == edge_cnt) begin
                e = q.pop_front();
                if (e.pm != 8'h00)
                    cmp8({e.name, ".pad"}, e.sel ? pad0 : pad, e.pe, e.pm);
                if (e.rm != 8'h00)
                    cmp8({e.name, ".rd_data"},
                         e.sel ? rd_data0 : rd_data, e.re, e.rm);
                if (e.cf) begin
                    cmp1({e.name, ".rd_valid"},
                         e.sel ? rd_valid0 : rd_valid, e.v);
                    cmp1({e.name, ".driving"},
                         e.sel ? driving0 : driving, e.d);
                    cmp1({e.name, ".dir_ready"},
                         e.sel ? dir_ready0 : dir_ready, e.r);
                end
            end
        end
    end

    task automatic step(input exp_t e);
        exp_t t;
        t = e;
        t.cyc = edge_cnt + 1;
        q.push_back(t);
        @(negedge clk);
    endtask

    task automatic req(input bit v, input bit d);
        dir_valid = v;
        dir_drive = d;
    endtask

    task automatic wr(input bit en, input logic [7:0] dat,
                      input logic [7:0] oe);
        wr_en   = en;
        wr_data = dat;
        wr_oe   = oe;
    endtask

    task automatic ext(input logic [7:0] oe, input logic [7:0] val);
        ext_oe  = oe;
        ext_val = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req(0, 0);
        wr(0, 8'h00, 8'h00);
        ext(8'hFF, 8'hA5);
        ext0_oe = 8'h00; ext0_val = 8'h00;
        @(negedge clk);

        // 1: reset with pads held externally
        step(ex("rst_a", 0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 1, 0, 0, 1));
        step(ex("rst_b", 0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 1, 0, 0, 1));
        rst_n = 1'b1;
        step(ex("rel_1", 0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 1, 0, 0, 1));
        step(ex("rel_2", 0, 8'hFF, 8'hA5, 8'hFF, 8'hA5, 1, 1, 0, 1));

        // 2: preload and go to drive
        ext(8'hFF, 8'hC3);
        wr(1, 8'h3C, 8'hFF);
        req(1, 1);
        step(ex("acc_drv", 0, 8'hFF, 8'hC3, 8'hFF, 8'hA5, 1, 0, 0, 0));
        wr(0, 8'h00, 8'h00);
        req(0, 0);
        step(ex("turn_drv", 0, 8'hFF, 8'hC3, 8'hFF, 8'hC3, 1, 0, 0, 0));
        ext(8'h00, 8'h00);
        step(ex("drive_on", 0, 8'hFF, 8'h3C, 8'h00, 8'h00, 1, 0, 1, 1));
        step(ex("drive_hold", 0, 8'hFF, 8'h3C, 8'h00, 8'h00, 1, 0, 1, 1));
        step(ex("readback", 0, 8'hFF, 8'h3C, 8'hFF, 8'h3C, 1, 0, 1, 1));

        // 3: partial output enable
        wr(1, 8'hFF, 8'h0F);
        step(ex("oe_low", 0, 8'h0F, 8'h0F, 8'h00, 8'h00, 1, 0, 1, 1));
        wr(0, 8'h00, 8'h00);
        ext(8'hF0, 8'hA0);
        step(ex("oe_mix", 0, 8'hFF, 8'hAF, 8'h00, 8'h00, 1, 0, 1, 1));
        step(ex("oe_rdbk", 0, 8'hFF, 8'hAF, 8'hFF, 8'hAF, 1, 0, 1, 1));
        ext(8'h00, 8'h00);

        // 4: same-direction no-op, then back to listen
        req(1, 1);
        step(ex("same_drv", 0, 8'h0F, 8'h0F, 8'h00, 8'h00, 1, 0, 1, 1));
        req(1, 0);
        step(ex("acc_rcv", 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
        req(0, 0);
        ext(8'hFF, 8'h5A);
        step(ex("turn_rcv", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        step(ex("listen_in", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        step(ex("settle_1", 0, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 1, 0, 0, 1));
        step(ex("settle_2", 0, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 1, 1, 0, 1));
        req(1, 0);
        step(ex("same_lsn", 0, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 1, 1, 0, 1));
        req(0, 0);

        // 5a: reset during TURN_DRV
        wr(1, 8'hFF, 8'hFF);
        req(1, 1);
        step(ex("pre_drv", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        wr(0, 8'h00, 8'h00);
        req(0, 0);
        rst_n = 1'b0;
        step(ex("rst_turn", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        rst_n = 1'b1;
        step(ex("rst_t_rel", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        req(1, 1);
        step(ex("clr_t1", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        req(0, 0);
        step(ex("clr_t2", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        step(ex("clr_drv", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 1, 1));

        // 5b: reset while driving
        ext(8'h00, 8'h00);
        wr(1, 8'h0F, 8'hFF);
        step(ex("drv_0f", 0, 8'hFF, 8'h0F, 8'h00, 8'h00, 1, 0, 1, 1));
        wr(0, 8'h00, 8'h00);
        ext(8'hFF, 8'h5A);
        rst_n = 1'b0;
        step(ex("rst_drive", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        rst_n = 1'b1;
        step(ex("rst_d_rel", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        req(1, 1);
        step(ex("clr2_t1", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        req(0, 0);
        step(ex("clr2_t2", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        step(ex("clr2_drv", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 1, 1));

        // 6a: request held while not ready
        req(1, 0);
        step(ex("hold_acc", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        req(1, 1);
        step(ex("hold_busy", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        step(ex("hold_rdy", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1));
        step(ex("hold_take", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        req(0, 0);
        step(ex("hold_t2", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
        step(ex("hold_drv", 0, 8'hFF, 8'h5A, 8'h00, 8'h00, 1, 0, 1, 1));

        // 6b: zero-turnaround build
        ext(8'h00, 8'h00);
        rst_n = 1'b0;
        step(ex("rst0", 1, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 1));
        rst_n = 1'b1;
        step(ex("rel0", 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1));
        wr(1, 8'h96, 8'hFF);
        req(1, 1);
        step(ex("acc0_drv", 1, 8'hFF, 8'h96, 8'h00, 8'h00, 1, 0, 1, 1));
        wr(0, 8'h00, 8'h00);
        req(1, 0);
        step(ex("acc0_lsn", 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1));
        req(0, 0);
        ext0_oe = 8'hFF; ext0_val = 8'h69;
        step(ex("lsn0_z", 1, 8'hFF, 8'h69, 8'h00, 8'h00, 1, 0, 0, 1));
        step(ex("settle0", 1, 8'hFF, 8'h69, 8'hFF, 8'h69, 1, 1, 0, 1));

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
